spike_router: RTL
=================

SPIKE_ROUTER -- requirements
Module: spike_router

Interface
REQ-001 Parameter N_NODES, 4, number of nodes, power of two, 2..16.
REQ-002 Parameter W, 8, synaptic weight width in bits.
REQ-003 Parameter IW, $clog2(N_NODES), node index width.
REQ-004 Port clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port cfg_we  input  1  configuration write strobe.
REQ-007 Port cfg_src  input  IW  source node of the synapse being written.
REQ-008 Port cfg_dst  input  IW  target node of the synapse being written.
REQ-009 Port cfg_conn  input  1  connection enable to store for (cfg_src, cfg_dst).
REQ-010 Port cfg_weight  input  W  weight to store for (cfg_src, cfg_dst).
REQ-011 Port spike_valid  input  1  spike vector offered.
REQ-012 Port spike_vec  input  N_NODES  bit i=1 means node i fired.
REQ-013 Port spike_ready  output  1  router can accept a spike vector.
REQ-014 Port ev_valid  output  1  synaptic event presented to the accumulators.
REQ-015 Port ev_ready  input  1  accumulator side accepts the event.
REQ-016 Port ev_src  output  IW  firing node of the event.
REQ-017 Port ev_dst  output  IW  target node whose accumulator adds ev_weight.
REQ-018 Port ev_weight  output  W  weight to accumulate.
REQ-019 Port busy  output  1  high in any state other than IDLE.

Function
REQ-020 Storage: N_NODES x N_NODES connection bits and W-bit weights, indexed [src][dst].
REQ-021 A config write occurs on a clk edge with cfg_we=1 and state IDLE; cfg_we is ignored in all other states.
REQ-022 Self-connections are unsupported: a write with cfg_src==cfg_dst is ignored, and the diagonal always reads 0.
REQ-023 FSM states: IDLE, SCAN, EMIT.
REQ-024 spike_ready=1 exactly when state is IDLE and rst=0.
REQ-025 Handshake: a spike vector is accepted on an edge with spike_valid & spike_ready; the accepted vector is latched as the pending mask.
REQ-026 An accepted vector of all zeros produces no events; the FSM remains in IDLE.
REQ-027 An accepted nonzero vector moves IDLE->SCAN with src = lowest set bit and dst = 0.
REQ-028 SCAN evaluates one (src,dst) pair per cycle.
REQ-029 In SCAN, a connected pair loads ev_src/ev_dst/ev_weight, sets ev_valid=1 and moves to EMIT.
REQ-030 In SCAN, an unconnected pair advances the scan pointer without emitting.
REQ-031 In EMIT, ev_valid and the event fields stay stable until ev_valid & ev_ready; on that edge ev_valid clears, the scan pointer advances and the FSM returns to SCAN, or to IDLE if the scan is complete.
REQ-032 Pointer advance when dst<N_NODES-1: dst+1.
REQ-033 Pointer advance when dst=N_NODES-1: clear src in the pending mask, move src to the next lowest set bit and set dst=0; if the mask becomes empty, go to IDLE.
REQ-034 Event order: ascending src, then ascending dst; each connected pair of each fired source is emitted exactly once per accepted vector.
REQ-035 Latency: for a vector accepted at edge T whose pair (src,0) is connected, ev_valid=1 after edge T+1.
REQ-036 Every accepted vector costs exactly popcount(spike_vec) x N_NODES SCAN cycles plus one EMIT cycle per event at ev_ready=1.
REQ-037 A new vector is never accepted while busy=1; spike_valid may be held by the source.
REQ-038 Weights pass through unmodified; the router performs no arithmetic on W.

Reset
REQ-039 While rst=1 at an edge: state becomes IDLE, pending mask 0, all connection bits 0, all weights 0, ev_valid 0, ev_src/ev_dst/ev_weight 0, busy 0.
REQ-040 rst overrides every other input, including mid-SCAN or mid-EMIT; an in-flight event is dropped and never completes.
REQ-041 spike_ready=1 on the first cycle after rst deasserts.

Verification
REQ-042 Config 0->1 w=5 and 0->3 w=9; spike_vec=0001 -> events (0,1,5) then (0,3,9); ev_valid first high 2 cycles after accept for (0,0)? No, because (0,0) is diagonal: first event appears after the SCAN cycles; then busy=0.
REQ-043 Same config, spike_vec=1011 with no connections from nodes 1 and 3 -> only the two node-0 events are emitted; busy for 3x4 SCAN cycles plus 2 EMIT cycles.
REQ-044 ev_ready=0 for 5 cycles during an EMIT -> ev_valid and all event fields hold constant; spike_ready stays 0; the stall adds exactly 5 cycles.
REQ-045 Write 2->2 and spike_vec=0000 -> the diagonal reads 0, no events are emitted, and spike_ready never drops.
REQ-046 cfg_we pulsed while busy -> the table is unchanged, so a later rescan shows the old weights.
REQ-047 rst asserted during EMIT -> ev_valid=0 on the next cycle; a subsequent spike on any node produces zero events because the table is cleared.

Source files
------------

// File: rtl/spike_router.sv
// Spike router: walks each fired source's outgoing synapses in ascending
// (src,dst) order and presents every connected pair as a handshaked event.
module spike_router #(
  parameter int N_NODES = 4,
  parameter int W       = 8,
  parameter int IW      = $clog2(N_NODES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_src,
  input  logic [IW-1:0]      cfg_dst,
  input  logic               cfg_conn,
  input  logic [W-1:0]       cfg_weight,
  input  logic               spike_valid,
  input  logic [N_NODES-1:0] spike_vec,
  output logic               spike_ready,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [IW-1:0]      ev_src,
  output logic [IW-1:0]      ev_dst,
  output logic [W-1:0]       ev_weight,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t                       state;
  logic [N_NODES-1:0]           mask;
  logic [IW-1:0]                src;
  logic [IW-1:0]                dst;
  logic [N_NODES*N_NODES-1:0]   conn;
  logic [W-1:0]                 weight [N_NODES*N_NODES];

  logic [2*IW-1:0]              idx;
  logic [2*IW-1:0]              cfg_idx;
  logic                         last_dst;
  logic [N_NODES-1:0]           mask_clr;
  logic [N_NODES-1:0]           adv_mask;
  logic [IW-1:0]                adv_src;
  logic [IW-1:0]                adv_dst;
  logic                         adv_done;

  function automatic logic [IW-1:0] lowest(input logic [N_NODES-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int i = N_NODES - 1; i >= 0; i--) begin
      if (m[i]) r = IW'(i);
    end
    return r;
  endfunction

  // N_NODES is a power of two, so {src,dst} is a dense flat index.
  assign idx      = {src, dst};
  assign cfg_idx  = {cfg_src, cfg_dst};

  // Scan pointer advance shared by an unconnected SCAN step and a completed EMIT.
  assign last_dst = (dst == IW'(N_NODES - 1));
  assign mask_clr = mask & ~({{(N_NODES-1){1'b0}}, 1'b1} << src);
  assign adv_mask = last_dst ? mask_clr : mask;
  assign adv_src  = last_dst ? lowest(mask_clr) : src;
  assign adv_dst  = last_dst ? '0 : dst + IW'(1);
  assign adv_done = last_dst && (mask_clr == '0);

  assign spike_ready = (state == IDLE) && !rst;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask      <= '0;
      src       <= '0;
      dst       <= '0;
      conn      <= '0;
      ev_valid  <= 1'b0;
      ev_src    <= '0;
      ev_dst    <= '0;
      ev_weight <= '0;
      for (int i = 0; i < N_NODES * N_NODES; i++) weight[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Diagonal entries are never written, so they stay at their reset 0.
          if (cfg_we && (cfg_src != cfg_dst)) begin
            conn[cfg_idx]   <= cfg_conn;
            weight[cfg_idx] <= cfg_weight;
          end
          if (spike_valid) begin
            mask <= spike_vec;
            src  <= lowest(spike_vec);
            dst  <= '0;
            if (spike_vec != '0) state <= SCAN;
          end
        end
        SCAN: begin
          if (conn[idx]) begin
            ev_valid  <= 1'b1;
            ev_src    <= src;
            ev_dst    <= dst;
            ev_weight <= weight[idx];
            state     <= EMIT;
          end else begin
            mask  <= adv_mask;
            src   <= adv_src;
            dst   <= adv_dst;
            state <= adv_done ? IDLE : SCAN;
          end
        end
        EMIT: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            mask     <= adv_mask;
            src      <= adv_src;
            dst      <= adv_dst;
            state    <= adv_done ? IDLE : SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
